booth_mult_arbiter: RTL
=======================

// Module: booth_mult_arbiter
// PURPOSE
//  Shares one free-running booth_mult instance among N_REQ requesters.
//  Arbitrates round-robin, loads the winner's operands onto the multiplier and discards the stale done pulse.
//  Captures the product and returns it, tagged with the requester ID, over a valid/ready response port.
//  Sits between client blocks and the booth_mult datapath; the multiplier is instantiated outside this block.
// PARAMETERS
//  D_IN      8   operand width, signed two's complement; product is 2*D_IN
//  N_REQ     4   number of requesters, 2..16
//  ID_W      2   requester ID width, equal to $clog2(N_REQ)
//  SKIP_DONE 1   number of mul_done pulses discarded after an operand load (0 or 1)
// PORTS
//  clk        in   1            clock, rising edge
//  rst_n      in   1            asynchronous reset, active-low
//  req_valid  in   N_REQ        per-requester operand valid
//  req_a      in   N_REQ*D_IN   packed operand A; requester i uses [i*D_IN +: D_IN]
//  req_b      in   N_REQ*D_IN   packed operand B, same packing as req_a
//  req_ready  out  N_REQ        one-hot accept; a transfer occurs when valid&ready at a clk edge
//  rsp_valid  out  1            product valid
//  rsp_ready  in   1            consumer accepts the product
//  rsp_id     out  ID_W         index of the requester that owns rsp_m
//  rsp_m      out  2*D_IN       signed product
//  mul_a      out  D_IN         operand A to booth_mult
//  mul_b      out  D_IN         operand B to booth_mult
//  mul_done   in   1            booth_mult done pulse
//  mul_m      in   2*D_IN       booth_mult product; valid while mul_done=1
//  busy       out  1            1 in any state other than IDLE
// BEHAVIOUR
//  Reset values (asynchronous):
//   - state=IDLE; req_ready=0; rsp_valid=0; rsp_id=0; rsp_m=0; mul_a=0; mul_b=0; busy=0
//   - round-robin pointer last=N_REQ-1, so the first grant after reset goes to requester 0
//  Outputs: all registered except req_ready.
//   - req_ready is combinational: asserted only in IDLE, one-hot on the winner.
//  Arbitration:
//   - Winner is the first i with req_valid[i]=1, scanning last+1, last+2, ... modulo N_REQ.
//   - On the transfer edge: last<=winner; rsp_id<=winner; mul_a/mul_b<=winner's operands.
//  Operand hold: mul_a and mul_b stay constant until the next transfer edge, never changing mid-operation.
//  FSM states and transitions:
//   - IDLE: any req_valid -> transfer; go to SKIP if SKIP_DONE=1, else WAIT.
//   - SKIP: mul_done=1 -> WAIT. This pulse may belong to an in-flight computation on old operands; its mul_m is dropped.
//   - WAIT: mul_done=1 -> rsp_m<=mul_m, rsp_valid<=1, go to RESP.
//   - RESP: rsp_valid&rsp_ready -> rsp_valid<=0, go to IDLE.
//  Response rules:
//   - rsp_m and rsp_id are held stable while rsp_valid=1 and rsp_ready=0.
//   - No grant while in RESP; back-to-back operations pass through one IDLE cycle.
//  Ignored events:
//   - mul_done in IDLE or RESP is ignored.
//   - req_valid changes outside IDLE have no effect.
//  Width: mul_m passes through unmodified (2*D_IN signed); no truncation or sign handling in this block.
//  Latency, with SKIP_DONE=1: transfer edge -> second mul_done edge -> rsp_valid=1 one cycle later.
//  Reset mid-operation: all state returns to reset values; the in-flight product is lost; the next mul_done is ignored in IDLE.
// TESTING  (D_IN=8, N_REQ=4, booth_mult instantiated in the bench)
//  1. Only req 0 valid, A=-1, B=-1 -> one req_ready[0] pulse; rsp_id=0, rsp_m=16'h0001.
//  2. All four valid from reset; A=-128, B=127 on each -> grants in order 0,1,2,3; each rsp_m=16'hC080.
//  3. Req 0 and req 2 held valid continuously, A=127, B=127 -> rsp_id alternates 0,2,0,2; rsp_m=16'h3F01.
//  4. rsp_ready=0 for 10 cycles after rsp_valid -> rsp_m and rsp_id stable; req_ready=0 throughout; busy=1.
//  5. Load A=-128, B=-128 right after a 1x1 operation -> the skipped pulse is not reported; rsp_m=16'h4000.
//  6. rst_n low during WAIT -> outputs at reset values; next grant goes to requester 0; no spurious rsp_valid.

Source files
------------

// File: rtl/booth_mult_arbiter.sv
// Round-robin arbiter that time-shares one free-running booth_mult among N_REQ
// requesters and returns each product tagged with its requester ID.
module booth_mult_arbiter #(
  parameter int D_IN      = 8,
  parameter int N_REQ     = 4,
  parameter int ID_W      = 2,
  parameter int SKIP_DONE = 1
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [N_REQ-1:0]       req_valid,
  input  logic [N_REQ*D_IN-1:0]  req_a,
  input  logic [N_REQ*D_IN-1:0]  req_b,
  output logic [N_REQ-1:0]       req_ready,
  output logic                   rsp_valid,
  input  logic                   rsp_ready,
  output logic [ID_W-1:0]        rsp_id,
  output logic [2*D_IN-1:0]      rsp_m,
  output logic [D_IN-1:0]        mul_a,
  output logic [D_IN-1:0]        mul_b,
  input  logic                   mul_done,
  input  logic [2*D_IN-1:0]      mul_m,
  output logic                   busy
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SKIP = 2'd1,
    WAIT = 2'd2,
    RESP = 2'd3
  } state_t;

  state_t              state_q;
  logic [ID_W-1:0]     last_q;
  logic [ID_W-1:0]     rsp_id_q;
  logic [2*D_IN-1:0]   rsp_m_q;
  logic                rsp_valid_q;
  logic [D_IN-1:0]     mul_a_q;
  logic [D_IN-1:0]     mul_b_q;
  logic                busy_q;

  logic                win_found;
  logic [ID_W-1:0]     win_idx;
  logic [D_IN-1:0]     win_a;
  logic [D_IN-1:0]     win_b;
  logic [N_REQ-1:0]    grant;

  // Scan starting just after the last winner; the first valid requester wins.
  always_comb begin
    win_found = 1'b0;
    win_idx   = '0;
    for (int unsigned k = 1; k <= N_REQ; k++) begin : scan
      int unsigned idx;
      idx = (32'(last_q) + k) % N_REQ;
      if (!win_found && req_valid[idx]) begin
        win_found = 1'b1;
        win_idx   = ID_W'(idx);
      end
    end
  end

  always_comb begin
    grant          = '0;
    grant[win_idx] = 1'b1;
    win_a          = req_a[32'(win_idx)*D_IN +: D_IN];
    win_b          = req_b[32'(win_idx)*D_IN +: D_IN];
  end

  assign req_ready = (state_q == IDLE && win_found) ? grant : '0;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      last_q      <= ID_W'(N_REQ - 1);
      rsp_id_q    <= '0;
      rsp_m_q     <= '0;
      rsp_valid_q <= 1'b0;
      mul_a_q     <= '0;
      mul_b_q     <= '0;
      busy_q      <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (win_found) begin
            last_q   <= win_idx;
            rsp_id_q <= win_idx;
            mul_a_q  <= win_a;
            mul_b_q  <= win_b;
            busy_q   <= 1'b1;
            state_q  <= (SKIP_DONE != 0) ? SKIP : WAIT;
          end
        end
        // The first pulse after a load may come from a computation on the
        // previous operands, so its product is dropped.
        SKIP: begin
          if (mul_done) state_q <= WAIT;
        end
        WAIT: begin
          if (mul_done) begin
            rsp_m_q     <= mul_m;
            rsp_valid_q <= 1'b1;
            state_q     <= RESP;
          end
        end
        RESP: begin
          if (rsp_ready) begin
            rsp_valid_q <= 1'b0;
            busy_q      <= 1'b0;
            state_q     <= IDLE;
          end
        end
        default: begin
          state_q <= IDLE;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign rsp_valid = rsp_valid_q;
  assign rsp_id    = rsp_id_q;
  assign rsp_m     = rsp_m_q;
  assign mul_a     = mul_a_q;
  assign mul_b     = mul_b_q;
  assign busy      = busy_q;

endmodule
